// File: rtl/cpu_pkg.sv
// Shared opcode, state and control-bundle definitions for the 8-bit accumulator CPU.
package cpu_pkg;
  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OP_AND = 3'b011;
  localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPC_W-1:0] OP_LDA = 3'b101;
  localparam logic [OPC_W-1:0] OP_STO = 3'b110;
  localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

  typedef enum logic [3:0] {
    ST_S0     = 4'd0,
    ST_S1     = 4'd1,
    ST_S2     = 4'd2,
    ST_S3     = 4'd3,
    ST_S4     = 4'd4,
    ST_S5     = 4'd5,
    ST_S6     = 4'd6,
    ST_S7     = 4'd7,
    ST_HALTED = 4'd8,
    ST_WAIT   = 4'd9
  } state_e;

  typedef struct packed {
    logic is_alu;
    logic is_lda;
    logic is_sto;
    logic is_jmp;
    logic is_skz;
    logic is_hlt;
  } opc_class_t;

  typedef struct packed {
    logic load_ir;
    logic rd;
    logic wr;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } ctl_t;
endpackage

// File: rtl/cpu_opc_class.sv
// Combinational opcode classifier: one-hot class bits for the sequencer decode.
module cpu_opc_class
  import cpu_pkg::*;
#(
  parameter int               OPC_W_P   = OPC_W,
  parameter logic [OPC_W_P-1:0] HALT_CODE = OP_HLT
) (
  input  logic [OPC_W_P-1:0] opc,
  output opc_class_t         cls
);
  logic hlt;

  assign hlt = (opc == HALT_CODE);

  always_comb begin
    cls = '0;
    cls.is_hlt = hlt;
    // A relocated halt code takes priority over whatever opcode shares its value.
    if (!hlt) begin
      case (opc)
        OP_ADD, OP_AND, OP_XOR: cls.is_alu = 1'b1;
        OP_LDA:                 cls.is_lda = 1'b1;
        OP_STO:                 cls.is_sto = 1'b1;
        OP_JMP:                 cls.is_jmp = 1'b1;
        OP_SKZ:                 cls.is_skz = 1'b1;
        default:                ;
      endcase
    end
  end
endmodule

// File: rtl/cpu_ctl_fsm.sv
// 8-cycle instruction sequencer (fetch x2, decode, execute x4) with halt.
// Build option CPU_CTL_SINGLE_STEP_EN adds a step input and a WAIT state after S7.
module cpu_ctl_fsm
  import cpu_pkg::*;
#(
  parameter int                 OPC_W_P   = OPC_W,
  parameter logic [OPC_W_P-1:0] HALT_CODE = OP_HLT
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               ena,
`ifdef CPU_CTL_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [OPC_W_P-1:0] opc,
  input  logic               zero,
  output logic               load_ir,
  output logic               rd,
  output logic               wr,
  output logic               inc_pc,
  output logic               load_pc,
  output logic               load_acc,
  output logic               datactl_ena,
  output logic               halt
);
  state_e     state, state_n;
  logic       skip, skip_n;
  opc_class_t cls;
  ctl_t       ctl;

  cpu_opc_class #(.OPC_W_P(OPC_W_P), .HALT_CODE(HALT_CODE)) u_cls (
    .opc (opc),
    .cls (cls)
  );

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state <= ST_S0;
      skip  <= 1'b0;
    end else begin
      state <= state_n;
      skip  <= skip_n;
    end
  end

  always_comb begin
    state_n = state;
    skip_n  = skip;
    ctl     = '0;
    case (state)
      ST_S0: begin
        ctl.load_ir = 1'b1; ctl.rd = 1'b1; ctl.inc_pc = 1'b1;
        state_n = ST_S1;
      end
      ST_S1: begin
        ctl.load_ir = 1'b1; ctl.rd = 1'b1; ctl.inc_pc = 1'b1;
        state_n = ST_S2;
      end
      ST_S2: state_n = ST_S3;
      ST_S3: begin
        ctl.halt = cls.is_hlt;
        state_n  = cls.is_hlt ? ST_HALTED : ST_S4;
      end
      ST_S4: begin
        ctl.rd          = cls.is_alu | cls.is_lda;
        ctl.datactl_ena = cls.is_sto;
        ctl.load_pc     = cls.is_jmp;
        state_n = ST_S5;
      end
      ST_S5: begin
        ctl.rd          = cls.is_alu | cls.is_lda;
        ctl.load_acc    = cls.is_alu | cls.is_lda;
        ctl.datactl_ena = cls.is_sto;
        ctl.wr          = cls.is_sto;
        ctl.load_pc     = cls.is_jmp;
        if (cls.is_skz) skip_n = zero;
        state_n = ST_S6;
      end
      ST_S6: begin
        // Bus stays driven one cycle past wr so the write data holds.
        ctl.datactl_ena = cls.is_sto;
        ctl.inc_pc      = cls.is_skz & skip;
        state_n = ST_S7;
      end
      ST_S7: begin
        ctl.inc_pc = cls.is_skz & skip;
        skip_n     = 1'b0;
`ifdef CPU_CTL_SINGLE_STEP_EN
        state_n = ST_WAIT;
`else
        state_n = ST_S0;
`endif
      end
      ST_HALTED: ctl.halt = 1'b1;
`ifdef CPU_CTL_SINGLE_STEP_EN
      ST_WAIT: if (step) state_n = ST_S0;
`endif
      default: state_n = ST_S0;
    endcase
    if (!ena) begin
      state_n = ST_S0;
      skip_n  = 1'b0;
    end
  end

  // Reset gating is combinational so outputs drop without waiting for a clock.
  assign {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt} =
         (ena && rst) ? ctl : '0;
endmodule

// File: tb/tb_cpu_ctl_fsm.sv
// Randomized and directed bench for cpu_ctl_fsm against an instruction-phase model.
module tb_cpu_ctl_fsm;
  logic       clk1 = 1'b0;
  logic       rst, ena, zero, step;
  logic [2:0] opc;
  logic       load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;
  logic [7:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase within the 8-cycle instruction, halted flag, skip flag.
  int m_ph   = 0;
  bit m_halt = 1'b0;
  bit m_skip = 1'b0;

  always #5 clk1 = ~clk1;

  cpu_ctl_fsm dut (
    .clk1        (clk1),
    .rst         (rst),
    .ena         (ena),
`ifdef CPU_CTL_SINGLE_STEP_EN
    .step        (step),
`endif
    .opc         (opc),
    .zero        (zero),
    .load_ir     (load_ir),
    .rd          (rd),
    .wr          (wr),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  assign outs = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b want %b (ph=%0d halt=%0b skip=%0b)",
               tag, $time, got, exp, m_ph, m_halt, m_skip);
    end
  endtask

  // Bits: load_ir rd wr inc_pc load_pc load_acc datactl_ena halt
  function automatic logic [7:0] exp_out(input bit en, input bit rs, input logic [2:0] op);
    bit alu, lda, sto, jmp, skz;
    logic [7:0] e;
    e = 8'b0;
    if (!en || !rs) return e;
    if (m_halt) return 8'b0000_0001;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
    lda = (op == 3'd5);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    skz = (op == 3'd1);
    case (m_ph)
      0, 1: e = 8'b1101_0000;
      3:    e = (op == 3'd0) ? 8'b0000_0001 : 8'b0;
      4:    e = {1'b0, alu | lda, 3'b0, 1'b0, sto, 1'b0} | {4'b0, jmp, 3'b0};
      5:    e = {1'b0, alu | lda, sto, 1'b0, jmp, alu | lda, sto, 1'b0};
      6:    e = {3'b0, skz & m_skip, 2'b0, sto, 1'b0};
      7:    e = {3'b0, skz & m_skip, 4'b0};
      default: e = 8'b0;
    endcase
    return e;
  endfunction

  task automatic advance(input bit en, input bit rs, input logic [2:0] op, input bit z);
    if (!rs || !en) begin
      m_ph = 0; m_halt = 1'b0; m_skip = 1'b0;
    end else if (!m_halt) begin
      if (m_ph == 3 && op == 3'd0) m_halt = 1'b1;
      else begin
        if (m_ph == 5 && op == 3'd1) m_skip = z;
        if (m_ph == 7) begin m_ph = 0; m_skip = 1'b0; end
        else m_ph++;
      end
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic cyc(input bit en, input bit rs, input logic [2:0] op, input bit z,
                     output logic [7:0] seen);
    ena = en; rst = rs; opc = op; zero = z;
    #4;
    seen = outs;
    chk("outs", outs, exp_out(en, rs, op));
    chk("excl", {5'b0, rd & wr, load_pc & inc_pc, datactl_ena & rd}, 8'b0);
    @(posedge clk1);
    advance(en, rs, op, z);
    #1;
  endtask

  task automatic instr(input logic [2:0] op, input bit z5, output int n_inc);
    logic [7:0] s;
    n_inc = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, op, (k == 5) ? z5 : 1'($urandom), s);
      n_inc += int'(s[4]);
    end
  endtask

  initial begin
    logic [7:0] s;
    logic [2:0] rop;
    int n_inc;
    bit en, rs;
    ena = 1'b0; rst = 1'b1; opc = 3'd0; zero = 1'b0; step = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk1); #1;

    repeat (3) cyc(1'b1, 1'b0, 3'd2, 1'b0, s);
    chk("reset_outs", s, 8'b0);

    // ADD, STO, SKZ taken/not taken, JMP
    instr(3'd2, 1'b0, n_inc);
    cyc(1'b1, 1'b1, 3'd2, 1'b0, s);
    chk("add_then_s0", s, 8'b1101_0000);
    for (int k = 1; k < 8; k++) cyc(1'b1, 1'b1, 3'd2, 1'b0, s);
    instr(3'd6, 1'b0, n_inc);
    instr(3'd1, 1'b1, n_inc);
    chk("skz_taken_inc", 8'(n_inc), 8'd4);
    instr(3'd1, 1'b0, n_inc);
    chk("skz_not_inc", 8'(n_inc), 8'd2);
    instr(3'd7, 1'b0, n_inc);
    chk("jmp_inc", 8'(n_inc), 8'd2);

    // LDA with ena dropped during S5
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 3'd5, 1'b0, s);
    cyc(1'b0, 1'b1, 3'd5, 1'b0, s);
    chk("ena_low_s5", s, 8'b0);
    cyc(1'b0, 1'b1, 3'd5, 1'b0, s);
    cyc(1'b1, 1'b1, 3'd5, 1'b0, s);
    chk("lda_restart", s, 8'b1101_0000);
    for (int k = 1; k < 8; k++) cyc(1'b1, 1'b1, 3'd5, 1'b0, s);

    // HLT held, then ena pulse low restarts
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 3'd0, 1'b0, s);
    chk("hlt_s3", s, 8'b0000_0001);
    repeat (20) cyc(1'b1, 1'b1, 3'($urandom), 1'($urandom), s);
    chk("halted_hold", s, 8'b0000_0001);
    cyc(1'b0, 1'b1, 3'd2, 1'b0, s);
    cyc(1'b1, 1'b1, 3'd2, 1'b0, s);
    chk("halt_restart", s, 8'b1101_0000);
    for (int k = 1; k < 8; k++) cyc(1'b1, 1'b1, 3'd2, 1'b0, s);

    // Asynchronous reset mid-cycle
    cyc(1'b1, 1'b1, 3'd4, 1'b0, s);
    ena = 1'b1; rst = 1'b1; opc = 3'd4; zero = 1'b0;
    #2;
    chk("pre_async", outs, exp_out(1'b1, 1'b1, 3'd4));
    rst = 1'b0;
    #1;
    chk("async_rst", outs, 8'b0);
    @(posedge clk1);
    advance(1'b1, 1'b0, 3'd4, 1'b0);
    #1;

    // Randomized run; opcode held per instruction as the IR would supply it
    rop = 3'($urandom);
    for (int n = 0; n < 800; n++) begin
      if (m_ph == 0 && !m_halt) rop = 3'($urandom);
      en = ($urandom_range(0, 24) != 0);
      rs = ($urandom_range(0, 99) != 0);
      cyc(en, rs, rop, 1'($urandom), s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_ctl_fsm.md
Name: cpu_ctl_fsm

Overview:
Instruction-sequencing controller for the 8-bit accumulator CPU. It sits directly upstream of the 16-bit instruction register: it drives that register's byte-load enable and consumes the opcode field the register produces. Every instruction runs an 8-cycle sequence: two byte fetches, decode, then up to four execute cycles. The block strobes PC, accumulator, ALU-output driver and memory rd/wr.

Parameters:
OPC_W, 3, opcode width; opcode = top OPC_W bits of the instruction register.
HALT_CODE, 3'b000, opcode value that halts the sequencer.

Ports:
clk1  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous, active-low reset
ena  in  1  run enable from start logic; low forces idle
opc  in  OPC_W  opcode from instruction register (opc_iraddr[15:13])
zero  in  1  accumulator-zero flag from ALU
load_ir  out  1  instruction register byte-load enable
rd  out  1  memory read strobe
wr  out  1  memory write strobe
inc_pc  out  1  PC increment
load_pc  out  1  PC parallel load (jump)
load_acc  out  1  accumulator load
datactl_ena  out  1  ALU-output bus driver enable
halt  out  1  CPU halted

Behaviour:
- Opcodes: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111. ALU class = ADD/AND/XOR.
- States: S0..S7 plus HALTED. The state register is 4 bits, binary encoded.
- rst low, asynchronous: state = S0, skip flag = 0. All outputs = 0 while rst is low and in the first S0 after release, until ena is high.
- ena low at a rising edge: next state = S0 and skip = 0, from any state including HALTED. All outputs are gated to 0 while ena = 0.
- Outputs are combinational Moore decode of the state, the registered skip flag and opc. They are valid for the whole cycle of the state.
- S0: load_ir=1, rd=1, inc_pc=1 (high byte). Next S1.
- S1: load_ir=1, rd=1, inc_pc=1 (low byte). Next S2. The IR has captured the high byte, so opc is valid from S1 onward.
- S2: all 0. Next S3.
- S3: if opc==HALT_CODE, halt=1 and next HALTED. Otherwise all 0 and next S4.
- S4: ALU/LDA gives rd=1. STO gives datactl_ena=1. JMP gives load_pc=1. Others all 0. Next S5.
- S5: ALU/LDA gives rd=1 and load_acc=1. STO gives datactl_ena=1 and wr=1. JMP gives load_pc=1. SKZ: skip <= zero at this edge. Next S6.
- S6: STO gives datactl_ena=1 (bus hold after wr). SKZ with skip=1 gives inc_pc=1. Next S7.
- S7: SKZ with skip=1 gives inc_pc=1, so two increments skip the next 2-byte instruction. Clear skip. Next S0.
- HALTED: halt=1, all other outputs 0. Stays until ena goes low, then S0.
- rd and wr are never high together. load_pc and inc_pc are never high together. datactl_ena is never high while rd is high.
- Throughput: one instruction per 8 cycles, with no bubbles between instructions.

Optional Feature:
CPU_CTL_SINGLE_STEP_EN
- Defined: adds input port step (1 bit). On leaving S7 the FSM enters WAIT, with all outputs 0. It advances to S0 on the first cycle step=1. ena low still forces S0.
- Undefined: no step port, no WAIT state; S7 goes directly to S0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_HLT..OP_JMP;
  - state encoding constants ST_S0..ST_S7, ST_HALTED, ST_WAIT;
  - OPC_W.
- The instruction register and ALU use the same opcode constants.
- One natural sub-module: cpu_opc_class. It is combinational and maps opc to one-hot class bits is_alu, is_lda, is_sto, is_jmp, is_skz, is_hlt. The FSM body decodes outputs from class bits only.

Test Plan:
- rst low 3 cycles, ena=1, rst high, opc=3'b010 (ADD): cycles 1-2 show load_ir=rd=inc_pc=1. Cycle 6 shows rd=load_acc=1. Cycle 9 is S0 again.
- opc=3'b110 (STO): datactl_ena=1 in S4-S6, wr=1 only in S5, rd=0 in S4-S7.
- opc=3'b001 (SKZ), zero=1 at S5: inc_pc=1 in S6 and S7, giving 4 total inc_pc cycles. Repeat with zero=0: only 2 inc_pc cycles.
- opc=3'b111 (JMP): load_pc=1 in S4-S5, inc_pc=0 in S2-S7.
- opc=3'b000 (HLT): halt=1 from S3, held 20 cycles with all else 0. Drop ena for 1 cycle, then raise it: restarts at S0 with load_ir=1.
- Drop ena mid-S5 of an LDA: next edge is S0 with all outputs 0. Reassert rst low asynchronously mid-cycle: outputs go 0 immediately with no clock edge.
